// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: widths, FSM states,
// next-PC select encodings and the branch offset field position.
package fetch_unit_pkg;

  localparam int unsigned PC_W = 16;
  localparam int unsigned IR_W = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] PCSEL_HOLD   = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_SEQ    = 2'd2;
  localparam logic [1:0] PCSEL_RET    = 2'd3;

  localparam int unsigned OFFSET_MSB = 10;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned OFFSET_W   = OFFSET_MSB - OFFSET_LSB + 1;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: hold, pc-relative branch, sequential, return.
module next_pc_calc #(
  parameter int unsigned PC_W = fetch_unit_pkg::PC_W
) (
  input  logic [PC_W-1:0]                     pc,
  input  logic [PC_W-1:0]                     ra,
  input  logic [fetch_unit_pkg::OFFSET_W-1:0] offset,
  input  logic [1:0]                          select,
  output logic [PC_W-1:0]                     next_pc,
  output logic [PC_W-1:0]                     pc_plus1
);
  import fetch_unit_pkg::*;

  logic [PC_W-1:0] offsetExt;

  assign offsetExt = {{(PC_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign pc_plus1  = pc + 1'b1;

  always_comb begin
    next_pc = pc;
    case (select)
      PCSEL_BRANCH: next_pc = pc + offsetExt;
      PCSEL_SEQ:    next_pc = pc_plus1;
      PCSEL_RET:    next_pc = ra;
      default:      next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM (FETCH/EXEC/HALT) owning the pc, ir and link register.
module fetch_unit #(
  parameter int unsigned PC_W = fetch_unit_pkg::PC_W,
  parameter int unsigned IR_W = fetch_unit_pkg::IR_W
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_rdata,
  output logic [IR_W-1:0] ir,
  output logic            ir_valid,
  input  logic [1:0]      choosePCUpdate,
  input  logic            ldRA,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] ra,
  output logic            halted
);
  import fetch_unit_pkg::*;

  state_t          state, stateNext;
  logic            execGo;
  logic [PC_W-1:0] nextPc, pcPlus1;

  next_pc_calc #(.PC_W(PC_W)) uNextPc (
    .pc       (pc),
    .ra       (ra),
    .offset   (ir[OFFSET_MSB:OFFSET_LSB]),
    .select   (choosePCUpdate),
    .next_pc  (nextPc),
    .pc_plus1 (pcPlus1)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      ra    <= '0;
    end else begin
      state <= stateNext;
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      if (execGo) pc <= nextPc;
      // ra captures pc+1 from the same edge, so a simultaneous return still uses the old ra
      if (execGo && ldRA) ra <= pcPlus1;
    end
  end

  always_comb begin
    stateNext = state;
    imem_req  = 1'b0;
    ir_valid  = 1'b0;
    halted    = 1'b0;
    execGo    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) stateNext = EXEC;
      end
      EXEC: begin
        ir_valid = 1'b1;
        if (!stall) begin
          execGo    = 1'b1;
          stateNext = (choosePCUpdate == PCSEL_HOLD) ? HALT : FETCH;
        end
      end
      HALT: halted = 1'b1;
      default: stateNext = FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic [1:0]  choosePCUpdate;
  logic        ldRA;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] ra;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.PC_W(16), .IR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .ir             (ir),
    .ir_valid       (ir_valid),
    .choosePCUpdate (choosePCUpdate),
    .ldRA           (ldRA),
    .stall          (stall),
    .pc             (pc),
    .ra             (ra),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds ack low for 'waits' FETCH cycles, then acks with 'word'; returns in EXEC.
  task automatic doFetch(input int unsigned waits, input logic [15:0] word);
    imem_ack = 1'b0;
    repeat (waits) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic execSel(input logic [1:0] sel);
    choosePCUpdate = sel;
    tick();
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    choosePCUpdate = 2'd2; ldRA = 1'b0; stall = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ra", ra, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_irvalid", {15'd0, ir_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_req", {15'd0, imem_req}, 16'd1);
    rst = 1'b0;

    // sequential fetches with one-cycle ack latency
    chk("seq_addr0", imem_addr, 16'h0000);
    doFetch(1, 16'h0001);
    chk("seq_ir0", ir, 16'h0001);
    chk("seq_valid0", {15'd0, ir_valid}, 16'd1);
    chk("seq_req_exec", {15'd0, imem_req}, 16'd0);
    execSel(2'd2);
    chk("seq_valid_off", {15'd0, ir_valid}, 16'd0);
    chk("seq_addr1", imem_addr, 16'h0001);
    doFetch(1, 16'h0002);
    execSel(2'd2);
    chk("seq_addr2", imem_addr, 16'h0002);

    // branches, zero-wait fetch; pc 2 + 14 = 0x10
    doFetch(0, 16'h000E);
    execSel(2'd1);
    chk("br_fwd", imem_addr, 16'h0010);
    doFetch(0, 16'hF7FC);
    execSel(2'd1);
    chk("br_neg4", imem_addr, 16'h000C);
    doFetch(0, 16'h07F2);
    execSel(2'd1);
    chk("br_wrap_neg", imem_addr, 16'hFFFE);
    doFetch(0, 16'h0003);
    execSel(2'd1);
    chk("br_wrap_pos", imem_addr, 16'h0001);
    doFetch(0, 16'h07FE);
    execSel(2'd1);
    chk("br_to_ffff", pc, 16'hFFFF);
    doFetch(0, 16'h0000);
    execSel(2'd2);
    chk("seq_wrap", pc, 16'h0000);
    doFetch(0, 16'h0020);
    execSel(2'd1);
    chk("br_to_20", pc, 16'h0020);

    // jal
    doFetch(0, 16'h0008);
    ldRA = 1'b1;
    execSel(2'd1);
    ldRA = 1'b0;
    chk("jal_ra", ra, 16'h0021);
    chk("jal_pc", imem_addr, 16'h0028);

    // stall for three cycles; ldRA, select and ack during stall must be ignored
    doFetch(2, 16'h1234);
    stall = 1'b1; ldRA = 1'b1; choosePCUpdate = 2'd3;
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    chk("stall_valid0", {15'd0, ir_valid}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {15'd0, ir_valid}, 16'd1);
      chk("stall_pc", pc, 16'h0028);
      chk("stall_ra", ra, 16'h0021);
      chk("stall_ir", ir, 16'h1234);
    end
    stall = 1'b0; ldRA = 1'b0; imem_ack = 1'b0;
    execSel(2'd3);
    chk("ret_valid_off", {15'd0, ir_valid}, 16'd0);
    chk("ret_pc", pc, 16'h0021);

    // return and link in the same cycle: pc takes old ra
    doFetch(0, 16'h0000);
    ldRA = 1'b1;
    execSel(2'd3);
    ldRA = 1'b0;
    chk("retlink_pc", pc, 16'h0021);
    chk("retlink_ra", ra, 16'h0022);

    // halt, then spurious acks
    doFetch(0, 16'h00FF);
    execSel(2'd0);
    chk("halt_flag", {15'd0, halted}, 16'd1);
    chk("halt_req", {15'd0, imem_req}, 16'd0);
    chk("halt_valid", {15'd0, ir_valid}, 16'd0);
    chk("halt_pc", pc, 16'h0021);
    imem_ack = 1'b1; imem_rdata = 16'hAAAA; choosePCUpdate = 2'd2;
    repeat (3) tick();
    imem_ack = 1'b0;
    chk("halt_stay", {15'd0, halted}, 16'd1);
    chk("halt_ir", ir, 16'h00FF);
    chk("halt_pc2", pc, 16'h0021);
    chk("halt_req2", {15'd0, imem_req}, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt_pc", pc, 16'h0000);
    chk("unhalt_ra", ra, 16'h0000);
    chk("unhalt_halted", {15'd0, halted}, 16'd0);
    chk("unhalt_req", {15'd0, imem_req}, 16'd1);

    // reset while waiting on a slow ack; ack in the reset cycle is discarded
    doFetch(0, 16'h0005);
    execSel(2'd2);
    chk("slow_addr", imem_addr, 16'h0001);
    repeat (2) tick();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    chk("abort_addr", imem_addr, 16'h0000);
    chk("abort_ir", ir, 16'h0000);
    chk("abort_valid", {15'd0, ir_valid}, 16'd0);
    chk("abort_req", {15'd0, imem_req}, 16'd1);
    doFetch(1, 16'h0002);
    chk("refetch_ir", ir, 16'h0002);
    chk("refetch_valid", {15'd0, ir_valid}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001: Parameter PC_W, 16, PC/address/link-register width.
REQ-002: Parameter IR_W, 16, instruction width.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: imem_req  output  1  instruction-memory read request.
REQ-006: imem_addr  output  PC_W  read address, equal to pc.
REQ-007: imem_ack  input  1  read data valid this cycle.
REQ-008: imem_rdata  input  IR_W  instruction word.
REQ-009: ir  output  IR_W  registered instruction, fed to the control decoder.
REQ-010: ir_valid  output  1  ir is executing this cycle; qualifies all register-file and memory writes.
REQ-011: choosePCUpdate  input  2  next-PC select from decoder: 0 hold/halt, 1 branch, 2 sequential, 3 return.
REQ-012: ldRA  input  1  load link register with return address.
REQ-013: stall  input  1  data-memory busy; freezes the EXEC state.
REQ-014: pc  output  PC_W  current instruction address.
REQ-015: ra  output  PC_W  link register.
REQ-016: halted  output  1  core halted.

Function
REQ-017: FSM states: FETCH, EXEC, HALT.
REQ-018: FETCH: imem_req=1, ir_valid=0; on imem_ack, ir<=imem_rdata, go to EXEC; otherwise stay.
REQ-019: EXEC: imem_req=0, ir_valid=1; choosePCUpdate/ldRA are sampled only in EXEC with stall=0.
REQ-020: EXEC with stall=1: stay in EXEC; pc, ir and ra unchanged; ir_valid stays 1.
REQ-021: EXEC with stall=0, select 2: pc<=pc+1; go to FETCH.
REQ-022: Select 1: pc<=pc+sext(ir[10:0]), relative to the current pc; go to FETCH.
REQ-023: Select 3: pc<=ra; go to FETCH.
REQ-024: Select 0: pc unchanged; go to HALT.
REQ-025: ldRA=1 in an accepted EXEC cycle: ra<=pc+1. With select 3 in the same cycle, pc takes the old ra.
REQ-026: HALT: imem_req=0, ir_valid=0, halted=1; leave HALT only through rst.
REQ-027: All PC arithmetic is modulo 2^PC_W; 0xFFFF+1 wraps to 0x0000, and negative offsets wrap the same way.
REQ-028: imem_ack outside FETCH is ignored, and ir is not updated.
REQ-029: An instruction takes at least 2 cycles: one ack cycle plus one EXEC cycle. Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction.

Reset
REQ-030: rst=1 at a clock edge sets state=FETCH, pc=0, ir=0, ra=0, halted=0, ir_valid=0. imem_req=1 from the first cycle after reset.
REQ-031: rst has priority over ack, stall and every select. Reset mid-fetch abandons the request, and an ack in the reset cycle is discarded.

Structure
REQ-032: A shared package holds PC_W, IR_W, the state enum, the select encodings (PCSEL_HOLD=0, PCSEL_BRANCH=1, PCSEL_SEQ=2, PCSEL_RET=3), and the offset field position [10:0].
REQ-033: One sub-module, next_pc_calc, is purely combinational. Inputs: pc, ra, offset, select. Outputs: next_pc and pc_plus1.
REQ-034: The remaining logic is the FSM plus the pc/ir/ra registers.

Verification
REQ-035: Reset, then ack with 1-cycle latency carrying an instruction with select=2 -> imem_addr 0,1,2 on successive fetches; ir_valid pulses once per instruction.
REQ-036: pc=0x0010, branch with ir[10:0]=0x7FC (-4) -> next imem_addr=0x000C. pc=0xFFFE, offset +3 -> 0x0001.
REQ-037: jal at pc=0x0020 (select=1, ldRA=1, offset +8) -> ra=0x0021, next pc=0x0028. A later select=3 -> pc=0x0021.
REQ-038: stall held 3 cycles in EXEC -> ir_valid high for 4 cycles; pc/ra unchanged until stall drops.
REQ-039: select=0 -> halted=1, imem_req=0 indefinitely; spurious imem_ack ignored; rst restores pc=0 and fetch.
REQ-040: rst asserted while waiting for a 5-cycle ack -> ack discarded; after reset, fetch restarts at address 0.
